// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the FIR filter family.
package fir_pkg;

   typedef enum logic [1:0] {
      CLEAR,
      LOAD,
      MAC,
      OUT
   } fir_dmc_state_t;

   localparam int SAT_W = 128;

   function automatic int acc_width(input int data_width, input int taps);
      return 2 * data_width + $clog2(taps);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Floor-shift out of fixed point, then clamp to a data_width-bit signed range.
   function automatic logic signed [SAT_W-1:0] sat_shift(
      input logic signed [SAT_W-1:0] acc,
      input int                      frac_bits,
      input int                      data_width
   );
      logic signed [SAT_W-1:0] shifted;
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      one     = SAT_W'(1);
      shifted = acc >>> frac_bits;
      max_v   = (one <<< (data_width - 1)) - one;
      min_v   = ~max_v;
      if (shifted > max_v)
         return max_v;
      else if (shifted < min_v)
         return min_v;
      return shifted;
   endfunction

endpackage

// File: rtl/fir_sample_buf.sv
// Per-channel circular sample history: one write port, one registered read port
// addressed by tap age k (k=0 is the newest sample of the channel).
module fir_sample_buf
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAPS       = 32,
   parameter int CHANNELS   = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 ptr_clr,
   input  logic                                 clr_en,
   input  logic [idx_width(CHANNELS*TAPS)-1:0]  clr_addr,
   input  logic                                 wr_en,
   input  logic [idx_width(CHANNELS)-1:0]       wr_ch,
   input  logic [DATA_WIDTH-1:0]                wr_data,
   input  logic [idx_width(CHANNELS)-1:0]       rd_ch,
   input  logic [idx_width(TAPS)-1:0]           rd_k,
   output logic [DATA_WIDTH-1:0]                rd_data
);

   localparam int DEPTH  = CHANNELS * TAPS;
   localparam int ADDR_W = idx_width(DEPTH);
   localparam int CH_W   = idx_width(CHANNELS);
   localparam int TAP_W  = idx_width(TAPS);

   logic [TAP_W-1:0]      wptr_reg [CHANNELS];
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_reg;
   logic [ADDR_W-1:0]     wr_addr;
   logic [ADDR_W-1:0]     rd_addr;
   logic [TAP_W:0]        k_eff;
   logic [TAP_W:0]        rd_sum;
   logic [TAP_W-1:0]      rd_slot;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_wptr
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               wptr_reg[gi] <= '0;
            else if (ptr_clr)
               wptr_reg[gi] <= '0;
            else if (wr_en && wr_ch == CH_W'(gi))
               wptr_reg[gi] <= (wptr_reg[gi] == TAP_W'(TAPS - 1)) ? '0 : wptr_reg[gi] + 1'b1;
         end
      end
   endgenerate

   // Read slot is (wptr-1-k) mod TAPS, formed as wptr+TAPS-1-k with one conditional wrap.
   always_comb begin
      wr_addr = ADDR_W'(wr_ch) * ADDR_W'(TAPS) + ADDR_W'(wptr_reg[wr_ch]);
      k_eff   = ({1'b0, rd_k} < (TAP_W+1)'(TAPS)) ? {1'b0, rd_k} : '0;
      rd_sum  = (TAP_W+1)'(wptr_reg[rd_ch]) + (TAP_W+1)'(TAPS - 1) - k_eff;
      rd_slot = (rd_sum >= (TAP_W+1)'(TAPS)) ? TAP_W'(rd_sum - (TAP_W+1)'(TAPS))
                                             : TAP_W'(rd_sum);
      rd_addr = ADDR_W'(rd_ch) * ADDR_W'(TAPS) + ADDR_W'(rd_slot);
   end

   always_ff @(posedge clk) begin
      if (clr_en)
         mem[clr_addr] <= '0;
      else if (wr_en)
         mem[wr_addr] <= wr_data;
      rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR: loads DECIMATION frames, then runs one shared
// MAC pass per channel and pushes each rescaled, saturated result downstream.
module fir_decim_mc
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAPS       = 32,
   parameter int DECIMATION = 8,
   parameter int CHANNELS   = 2,
   parameter int FRAC_BITS  = 10,
   parameter logic signed [DATA_WIDTH-1:0] COEFF [TAPS] = '{default: '0}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic                  x_in_empty,
   output logic                  x_in_rd_en,
   output logic [DATA_WIDTH-1:0] y_out,
   output logic                  y_out_wr_en,
   input  logic                  y_out_full
);

   localparam int ACC_W    = acc_width(DATA_WIDTH, TAPS);
   localparam int PROD_W   = 2 * DATA_WIDTH;
   localparam int CH_W     = idx_width(CHANNELS);
   localparam int TAP_W    = idx_width(TAPS);
   localparam int ADDR_W   = idx_width(CHANNELS * TAPS);
   localparam int CLR_LEN  = CHANNELS * TAPS;
   localparam int LOAD_LEN = CHANNELS * DECIMATION;
   localparam int MAC_LEN  = TAPS + 2;
   localparam int CNT_MAX0 = (CLR_LEN > LOAD_LEN) ? CLR_LEN : LOAD_LEN;
   localparam int CNT_MAX  = (CNT_MAX0 > MAC_LEN) ? CNT_MAX0 : MAC_LEN;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   fir_dmc_state_t state_reg, state_next;
   logic [CNT_W-1:0]         cnt_reg, cnt_next;
   logic [CH_W-1:0]          ch_reg, ch_next;
   logic signed [ACC_W-1:0]  acc_reg, acc_next;
   logic signed [PROD_W-1:0] prod_reg;
   logic [DATA_WIDTH-1:0]    y_reg;
   logic [DATA_WIDTH-1:0]    buf_rd_data;
   logic signed [DATA_WIDTH-1:0] sample_s;
   logic signed [DATA_WIDTH-1:0] coeff_sel;
   logic [TAP_W-1:0]         coeff_idx;
   logic signed [SAT_W-1:0]  sat_in;

   fir_sample_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAPS       (TAPS),
      .CHANNELS   (CHANNELS)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .ptr_clr  (state_reg == CLEAR),
      .clr_en   (state_reg == CLEAR),
      .clr_addr (ADDR_W'(cnt_reg)),
      .wr_en    (x_in_rd_en),
      .wr_ch    (ch_reg),
      .wr_data  (x_in),
      .rd_ch    (ch_reg),
      .rd_k     (TAP_W'(cnt_reg)),
      .rd_data  (buf_rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= CLEAR;
         cnt_reg   <= '0;
         ch_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ch_reg    <= ch_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      ch_next     = ch_reg;
      x_in_rd_en  = 1'b0;
      y_out_wr_en = 1'b0;
      if (flush) begin
         state_next = CLEAR;
         cnt_next   = '0;
         ch_next    = '0;
      end else begin
         case (state_reg)
            CLEAR: begin
               if (cnt_reg == CNT_W'(CLR_LEN - 1)) begin
                  state_next = LOAD;
                  cnt_next   = '0;
                  ch_next    = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            LOAD: begin
               if (!x_in_empty) begin
                  x_in_rd_en = 1'b1;
                  ch_next    = (ch_reg == CH_W'(CHANNELS - 1)) ? '0 : ch_reg + 1'b1;
                  if (cnt_reg == CNT_W'(LOAD_LEN - 1)) begin
                     state_next = MAC;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end
            MAC: begin
               if (cnt_reg == CNT_W'(MAC_LEN - 1)) begin
                  state_next = OUT;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            OUT: begin
               if (!y_out_full) begin
                  y_out_wr_en = 1'b1;
                  cnt_next    = '0;
                  if (ch_reg == CH_W'(CHANNELS - 1)) begin
                     state_next = LOAD;
                     ch_next    = '0;
                  end else begin
                     state_next = MAC;
                     ch_next    = ch_reg + 1'b1;
                  end
               end
            end
            default: state_next = CLEAR;
         endcase
      end
   end

   // Pipeline: read issued at cnt=k, product formed at cnt=k+1, accumulated at cnt=k+2.
   always_comb begin
      sample_s  = $signed(buf_rd_data);
      coeff_idx = TAP_W'(CNT_W'(TAPS) - cnt_reg);
      coeff_sel = '0;
      if (cnt_reg >= CNT_W'(1) && cnt_reg <= CNT_W'(TAPS))
         coeff_sel = COEFF[coeff_idx];
      acc_next = acc_reg + ACC_W'(prod_reg);
      sat_in   = SAT_W'(acc_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg  <= '0;
         prod_reg <= '0;
         y_reg    <= '0;
      end else if (state_reg == MAC && !flush) begin
         if (cnt_reg == '0)
            acc_reg <= '0;
         else if (cnt_reg >= CNT_W'(2))
            acc_reg <= acc_next;
         if (cnt_reg >= CNT_W'(1) && cnt_reg <= CNT_W'(TAPS))
            prod_reg <= PROD_W'(sample_s) * PROD_W'(coeff_sel);
         if (cnt_reg == CNT_W'(MAC_LEN - 1))
            y_reg <= DATA_WIDTH'(sat_shift(sat_in, FRAC_BITS, DATA_WIDTH));
      end
   end

   assign y_out = y_reg;

endmodule
